// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-read-port register file.
//   clr_state_e : clear-engine state encoding (CLEAR, READY)
//   idx_width   : index width for a given register count (never below 1 bit)
//   sel_lsb     : LSB of read-port k inside the packed selRs_i bus
//   data_lsb    : LSB of read-port k inside the packed rs_o bus
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int idx_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    function automatic int sel_lsb(input int port, input int aw);
        return port * aw;
    endfunction

    function automatic int data_lsb(input int port, input int xlen);
        return port * xlen;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_clear_ctrl
// Sequential clear engine: zeroes one register per cycle, started by reset or
// by a soft-clear request while idle.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-low reset (restarts the sweep at index 0)
//   clr_i       : soft-clear request, honoured only in READY
//   busy_o      : registered, high while the sweep is running
//   clear_we_o  : write strobe for the current sweep index
//   clear_idx_o : register index being zeroed this cycle
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CLEAR | sweeping, mem[cnt] <= 0 every cycle, user traffic blocked
//   READY | idle, normal reads/writes, waiting for clr_i
// -----------------------------------------------------------------------------
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = idx_width(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          clear_we_o,
    output logic [AW-1:0] clear_idx_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    // clr_i is deliberately not looked at here: a running
                    // sweep is never restarted by a soft clear.
                    if (cnt_q == LAST_IDX) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                READY: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign clear_we_o  = (state_q == CLEAR);
    assign clear_idx_o = cnt_q;

endmodule

// File: rtl/registerfile_mp.sv
// -----------------------------------------------------------------------------
// registerfile_mp
// Parametrised register file with NREAD registered read ports, one write port,
// optional hardwired-zero register 0 and a sequential clear engine.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-low reset
//   clr_i    : soft-clear request (ignored while a clear is running)
//   busy_o   : clear sequence in progress
//   we_i     : write enable;  selRd_i : write index;  rd_i : write data
//   re_i     : read enable for all ports
//   selRs_i  : read indices, port k at [k*AW +: AW]
//   rs_o     : read data, port k at [k*XLEN +: XLEN], held when not reading
//   valid_o  : rs_o was updated by the last edge
//
// Build option: define REGFILE_BYPASS_EN for write-first behaviour on a
// same-cycle write/read of the same index; otherwise reads are read-first.
// -----------------------------------------------------------------------------
module registerfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = idx_width(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         selRd_i,
    input  logic [XLEN-1:0]       rd_i,
    input  logic                  re_i,
    input  logic [NREAD*AW-1:0]   selRs_i,
    output logic [NREAD*XLEN-1:0] rs_o,
    output logic                  valid_o
);

    // One extra bit so NREGS itself is representable for the range check.
    localparam logic [AW:0] NREGS_X = (AW+1)'(NREGS);

    logic            busy;
    logic            clear_we;
    logic [AW-1:0]   clear_idx;

    logic [XLEN-1:0] mem [NREGS];

    logic            wr_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [XLEN-1:0] mem_wdata;

    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] rd_word;

    logic [NREAD*XLEN-1:0] rs_d, rs_q;
    logic                  valid_d, valid_q;

    function automatic logic idx_in_range(input logic [AW-1:0] idx);
        return ({1'b0, idx} < NREGS_X);
    endfunction

    function automatic logic idx_is_zero_reg(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    regfile_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .busy_o      (busy),
        .clear_we_o  (clear_we),
        .clear_idx_o (clear_idx)
    );

    // Write path: the clear engine owns the port while busy; a user write is
    // dropped when it collides with a clear request.
    always_comb begin
        wr_ok = !busy && we_i && !clr_i &&
                idx_in_range(selRd_i) && !idx_is_zero_reg(selRd_i);
        if (busy) begin
            mem_we    = rst_i && clear_we;
            mem_idx   = clear_idx;
            mem_wdata = '0;
        end else begin
            mem_we    = rst_i && wr_ok;
            mem_idx   = selRd_i;
            mem_wdata = rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Read path: outputs hold unless a read is accepted in READY.
    always_comb begin
        rs_d    = rs_q;
        valid_d = 1'b0;
        rd_idx  = '0;
        rd_word = '0;
        if (!busy && re_i) begin
            valid_d = 1'b1;
            for (int k = 0; k < NREAD; k++) begin
                rd_idx = selRs_i[sel_lsb(k, AW) +: AW];
                if (!idx_in_range(rd_idx) || idx_is_zero_reg(rd_idx)) begin
                    rd_word = '0;
                end
`ifdef REGFILE_BYPASS_EN
                else if (wr_ok && (selRd_i == rd_idx)) begin
                    rd_word = rd_i;
                end
`endif
                else begin
                    rd_word = mem[rd_idx];
                end
                rs_d[data_lsb(k, XLEN) +: XLEN] = rd_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rs_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            rs_q    <= rs_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = busy;
    assign rs_o    = rs_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_registerfile_mp.sv
// -----------------------------------------------------------------------------
// tb_registerfile_mp
// Bench for registerfile_mp: a 32x32 two-port instance (dut) and a 24-entry
// three-port instance (dut2) sharing clock and reset. Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_registerfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    localparam int NREGS2 = 24;
    localparam int NREAD2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  clr;
    logic                  busy;
    logic                  we;
    logic [AW-1:0]         sel_rd;
    logic [XLEN-1:0]       rd;
    logic                  re;
    logic [NREAD*AW-1:0]   sel_rs;
    logic [NREAD*XLEN-1:0] rs;
    logic                  valid;

    logic                   clr2;
    logic                   busy2;
    logic                   we2;
    logic [AW-1:0]          sel_rd2;
    logic [XLEN-1:0]        rd2;
    logic                   re2;
    logic [NREAD2*AW-1:0]   sel_rs2;
    logic [NREAD2*XLEN-1:0] rs2;
    logic                   valid2;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0]         model [NREGS];
    logic [NREAD*XLEN-1:0]   exp_q [$];
    logic [NREAD*XLEN-1:0]   last_rs;
    logic [XLEN-1:0]         model2 [NREGS2];
    logic [NREAD2*XLEN-1:0]  exp_q2 [$];

    registerfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy),
        .we_i(we), .selRd_i(sel_rd), .rd_i(rd),
        .re_i(re), .selRs_i(sel_rs), .rs_o(rs), .valid_o(valid)
    );

    registerfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS2), .NREAD(NREAD2), .ZERO_REG(1)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr2), .busy_o(busy2),
        .we_i(we2), .selRd_i(sel_rd2), .rd_i(rd2),
        .re_i(re2), .selRs_i(sel_rs2), .rs_o(rs2), .valid_o(valid2)
    );

    function automatic logic [XLEN-1:0] exp_word(input logic [AW-1:0] idx, input logic w,
                                                 input logic [AW-1:0] wsel, input logic [XLEN-1:0] wdata);
        if (idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (w && (wsel == idx)) return wdata;
`endif
        return model[idx];
    endfunction

    // One READY-state cycle on dut: expected read data is queued at drive time
    // and popped once the DUT has produced its registered output.
    task automatic cycle(input logic we_v, input logic [AW-1:0] wsel, input logic [XLEN-1:0] wdata,
                         input logic re_v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input string name);
        logic [NREAD*XLEN-1:0] exp_rs;
        we = we_v; sel_rd = wsel; rd = wdata; re = re_v; sel_rs = {r1, r0};
        if (re_v) exp_q.push_back({exp_word(r1, we_v, wsel, wdata), exp_word(r0, we_v, wsel, wdata)});
        if (we_v && (wsel != '0)) model[wsel] = wdata;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        vectors++;
        if (valid !== re_v) begin
            miscompares++;
            $display("FAIL %s valid: got %b expected %b", name, valid, re_v);
        end
        if (re_v) begin
            exp_rs  = exp_q.pop_front();
            last_rs = exp_rs;
        end else begin
            exp_rs = last_rs;
        end
        vectors++;
        if (rs !== exp_rs) begin
            miscompares++;
            $display("FAIL %s rs: got %h expected %h", name, rs, exp_rs);
        end
    endtask

    // Counts cycles with busy high, starting with the current one. While busy,
    // random writes/reads are thrown at dut; they must have no effect.
    task automatic count_busy(input int expected, input int reclr_at, input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            we = 1'b1; sel_rd = AW'($urandom_range(1, NREGS - 1)); rd = $urandom;
            re = 1'b1; sel_rs = NREAD*AW'($urandom);
            clr = (n == reclr_at);
            @(posedge clk); #1;
            vectors++;
            if (valid !== 1'b0 || rs !== last_rs) begin
                miscompares++;
                $display("FAIL %s busy_io: valid %b rs %h, expected valid 0 rs %h", name, valid, rs, last_rs);
            end
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        vectors++;
        if (n != expected) begin
            miscompares++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, n, expected);
        end
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        int n2 = 0;
        int n  = 0;
        rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; sel_rd = '0; rd = '0; sel_rs = '0;
        clr2 = 1'b0; we2 = 1'b0; re2 = 1'b0; sel_rd2 = '0; rd2 = '0; sel_rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        last_rs = '0;
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0 || rs !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy %b valid %b rs %h, expected 1 0 0", busy, valid, rs);
        end
        rst = 1'b1;
        while ((busy === 1'b1 || busy2 === 1'b1) && n < 100) begin
            if (busy === 1'b1) n++;
            if (busy2 === 1'b1) n2++;
            @(posedge clk); #1;
        end
        vectors++;
        if (n != NREGS) begin
            miscompares++;
            $display("FAIL reset_busy_len: got %0d expected %0d", n, NREGS);
        end
        vectors++;
        if (n2 != NREGS2) begin
            miscompares++;
            $display("FAIL reset_busy_len_24: got %0d expected %0d", n2, NREGS2);
        end
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 0; i < NREGS2; i++) model2[i] = '0;
        for (int i = 0; i < NREGS; i++) cycle(1'b0, '0, '0, 1'b1, AW'(i), AW'(NREGS - 1 - i), "reset_read_all");
    endtask

    task automatic test_write_read();
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, "write_r5");
        cycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd0, "read_r5_r0");
        cycle(1'b0, '0, '0, 1'b0, '0, '0, "read_hold");
        cycle(1'b1, 5'd31, 32'h0BADF00D, 1'b1, 5'd31, 5'd5, "write_r31_read");
        cycle(1'b0, '0, '0, 1'b1, 5'd31, 5'd31, "read_r31");
    endtask

    task automatic test_zero_reg();
        cycle(1'b1, 5'd0, 32'h00001234, 1'b0, '0, '0, "write_r0");
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 5'd5, "read_r0");
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, "write_read_r0");
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 5'd7, 32'h00000001, 1'b0, '0, '0, "seed_r7");
        cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7, "same_cycle_r7");
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 5'd3, "after_same_cycle_r7");
    endtask

    task automatic test_soft_clear();
        for (int i = 1; i < NREGS; i++)
            cycle(1'b1, AW'(i), XLEN'(i) * 32'h01010101 ^ 32'hC0DE0000, 1'b1, AW'(i - 1), AW'(i), "fill");
        cycle(1'b0, '0, '0, 1'b1, 5'd17, 5'd30, "fill_check");
        // Clear request together with a write: the write must be dropped.
        clr = 1'b1; we = 1'b1; sel_rd = 5'd3; rd = 32'h33333333;
        @(posedge clk); #1;
        clr = 1'b0; we = 1'b0;
        count_busy(NREGS, 5, "soft_clear");
        for (int i = 0; i < NREGS; i += 2) cycle(1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1), "after_clear");
    endtask

    task automatic test_reset_mid_clear();
        cycle(1'b1, 5'd9, 32'h99999999, 1'b0, '0, '0, "pre_mid_write");
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        last_rs = '0;
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0 || rs !== '0) begin
            miscompares++;
            $display("FAIL mid_clear_reset: busy %b valid %b rs %h, expected 1 0 0", busy, valid, rs);
        end
        rst = 1'b1;
        count_busy(NREGS, 0, "mid_clear_release");
        cycle(1'b0, '0, '0, 1'b1, 5'd9, 5'd31, "after_mid_clear");
    endtask

    task automatic test_multiport();
        logic [NREAD2*XLEN-1:0] exp2;
        int n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL mp_ready: got busy %b expected 0", busy2);
        end
        for (int i = 0; i < NREGS2; i++) model2[i] = '0;
        for (int j = 0; j < 6; j++) begin
            int widx;
            case (j)
                0: widx = 30;
                1: widx = 24;
                2: widx = 1;
                3: widx = 2;
                4: widx = 23;
                default: widx = 0;
            endcase
            we2 = 1'b1; sel_rd2 = AW'(widx); rd2 = 32'h10000000 * (j + 1) + 32'h00ABCDEF;
            if (widx > 0 && widx < NREGS2) model2[widx] = rd2;
            @(posedge clk); #1;
            we2 = 1'b0;
        end
        for (int t = 0; t < 3; t++) begin
            logic [AW-1:0] s0, s1, s2;
            case (t)
                0: begin s0 = 5'd1;  s1 = 5'd2; s2 = 5'd23; end
                1: begin s0 = 5'd30; s1 = 5'd0; s2 = 5'd24; end
                default: begin s0 = 5'd23; s1 = 5'd31; s2 = 5'd1; end
            endcase
            re2 = 1'b1; sel_rs2 = {s2, s1, s0};
            exp_q2.push_back({(s2 < NREGS2 && s2 != 0) ? model2[s2] : '0,
                              (s1 < NREGS2 && s1 != 0) ? model2[s1] : '0,
                              (s0 < NREGS2 && s0 != 0) ? model2[s0] : '0});
            @(posedge clk); #1;
            re2 = 1'b0;
            exp2 = exp_q2.pop_front();
            vectors++;
            if (valid2 !== 1'b1 || rs2 !== exp2) begin
                miscompares++;
                $display("FAIL mp_read%0d: valid %b rs %h, expected valid 1 rs %h", t, valid2, rs2, exp2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_soft_clear();
        test_reset_mid_clear();
        test_multiport();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
